// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// classes, PC mux selects and the default watchdog limit.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    MDWAIT = 3'd5,
    EXC    = 3'd6
  } state_t;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;
  localparam logic [2:0] CLS_MULDIV = 3'd5;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_EXC    = 2'd3;

  localparam int WDOG_LIMIT_DEFAULT = 63;

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Watchdog for the controller's wait states: counts stalled cycles and flags
// when the count has reached LIMIT.
module wait_timer
  import mc_pkg::*;
#(
  parameter int LIMIT = WDOG_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [5:0] count;

  // Saturates at LIMIT; the controller leaves the wait state on expiry anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + 6'd1;
    end
  end

  assign expired = (count == 6'(LIMIT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables combinationally from the current state.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] instr_class,
  input  logic       branch_taken,
  input  logic       mem_ready,
  input  logic       md_done,
  output logic       pc_ena,
  output logic       ir_ena,
  output logic       a_ena,
  output logic       b_ena,
  output logic       alu_ena,
  output logic       mdr_ena,
  output logic       rf_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       md_start,
  output logic       exc,
  output logic [1:0] pc_src,
  output logic [2:0] state
);

  state_t cur_state;
  state_t next_state;
  logic   waiting;
  logic   ready;
  logic   expired;
  logic   timer_clr;
  logic   timer_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  // Ready/done is checked before the watchdog so a late acknowledge still wins.
  always_comb begin
    next_state = cur_state;
    waiting    = 1'b0;
    ready      = 1'b0;
    case (cur_state)
      FETCH: begin
        if (run) begin
          waiting = 1'b1;
          ready   = mem_ready;
          if (mem_ready) begin
            next_state = DECODE;
          end else if (expired) begin
            next_state = EXC;
          end
        end
      end
      DECODE: next_state = (instr_class[2:1] == 2'b11) ? EXC : EXEC;
      EXEC: begin
        case (instr_class)
          CLS_ALU:              next_state = WB;
          CLS_LOAD, CLS_STORE:  next_state = MEM;
          CLS_MULDIV:           next_state = MDWAIT;
          default:              next_state = FETCH;
        endcase
      end
      MEM: begin
        waiting = 1'b1;
        ready   = mem_ready;
        if (mem_ready) begin
          next_state = (instr_class == CLS_LOAD) ? WB : FETCH;
        end else if (expired) begin
          next_state = EXC;
        end
      end
      MDWAIT: begin
        waiting = 1'b1;
        ready   = md_done;
        if (md_done) begin
          next_state = WB;
        end else if (expired) begin
          next_state = EXC;
        end
      end
      WB:      next_state = FETCH;
      EXC:     next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  assign timer_clr = (next_state != cur_state) || (cur_state == FETCH && !run);
  assign timer_inc = waiting && !ready;

  wait_timer #(
    .LIMIT(WDOG_LIMIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .expired(expired)
  );

  // Outputs are forced low while reset is held, even though the state is FETCH.
  always_comb begin
    pc_ena   = 1'b0;
    ir_ena   = 1'b0;
    a_ena    = 1'b0;
    b_ena    = 1'b0;
    alu_ena  = 1'b0;
    mdr_ena  = 1'b0;
    rf_we    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    md_start = 1'b0;
    exc      = 1'b0;
    pc_src   = PC_SEQ;
    if (!rst) begin
      case (cur_state)
        FETCH: begin
          if (run) begin
            mem_req = 1'b1;
            if (mem_ready) begin
              ir_ena = 1'b1;
              pc_ena = 1'b1;
            end
          end
        end
        DECODE: begin
          a_ena = 1'b1;
          b_ena = 1'b1;
        end
        EXEC: begin
          case (instr_class)
            CLS_ALU, CLS_LOAD, CLS_STORE: alu_ena = 1'b1;
            CLS_BRANCH: begin
              pc_ena = branch_taken;
              pc_src = PC_BRANCH;
            end
            CLS_JUMP: begin
              pc_ena = 1'b1;
              pc_src = PC_JUMP;
            end
            CLS_MULDIV: md_start = 1'b1;
            default: ;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = (instr_class == CLS_STORE);
          mdr_ena = mem_ready && (instr_class == CLS_LOAD);
        end
        WB: rf_we = 1'b1;
        EXC: begin
          exc    = 1'b1;
          pc_ena = 1'b1;
          pc_src = PC_EXC;
        end
        default: ;
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle input/output trace from the latency and wait rules, then replayed.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  localparam int WL = 63;

  localparam logic [12:0] O_PC   = 13'h1000;
  localparam logic [12:0] O_IR   = 13'h0800;
  localparam logic [12:0] O_A    = 13'h0400;
  localparam logic [12:0] O_B    = 13'h0200;
  localparam logic [12:0] O_ALU  = 13'h0100;
  localparam logic [12:0] O_MDR  = 13'h0080;
  localparam logic [12:0] O_RF   = 13'h0040;
  localparam logic [12:0] O_MREQ = 13'h0020;
  localparam logic [12:0] O_MWE  = 13'h0010;
  localparam logic [12:0] O_MDS  = 13'h0008;
  localparam logic [12:0] O_EXC  = 13'h0004;

  typedef struct {
    bit          run;
    bit          mr;
    bit          md;
    bit          bt;
    logic [2:0]  cls;
    logic [12:0] eo;
    logic [2:0]  es;
  } cyc_t;

  logic clk, rst, run, branch_taken, mem_ready, md_done;
  logic [2:0] instr_class;
  logic pc_ena, ir_ena, a_ena, b_ena, alu_ena, mdr_ena, rf_we;
  logic mem_req, mem_we, md_start, exc;
  logic [1:0] pc_src;
  logic [2:0] dut_state;
  logic [12:0] outs;

  cyc_t trace[$];
  logic [12:0] obs_o[$];
  logic [2:0] obs_s[$];
  int tests = 0;
  int failed = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .instr_class(instr_class),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .md_done(md_done),
    .pc_ena(pc_ena), .ir_ena(ir_ena), .a_ena(a_ena), .b_ena(b_ena),
    .alu_ena(alu_ena), .mdr_ena(mdr_ena), .rf_we(rf_we), .mem_req(mem_req),
    .mem_we(mem_we), .md_start(md_start), .exc(exc), .pc_src(pc_src),
    .state(dut_state)
  );

  assign outs = {pc_ena, ir_ena, a_ena, b_ena, alu_ena, mdr_ena, rf_we,
                 mem_req, mem_we, md_start, exc, pc_src};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit nz();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rnd_cls();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic push(input bit r, input bit mr, input bit md, input bit bt,
                      input logic [2:0] c, input logic [12:0] eo, input logic [2:0] es);
    cyc_t x;
    x.run = r; x.mr = mr; x.md = md; x.bt = bt; x.cls = c; x.eo = eo; x.es = es;
    trace.push_back(x);
  endtask

  task automatic push_exc(input logic [2:0] c);
    push(nz(), nz(), nz(), nz(), c, O_PC | O_EXC | 13'(PC_EXC), EXC);
  endtask

  // Awaited signal arrives after w stalled cycles; more than WL stalls means a watchdog exception.
  task automatic build_instr(input logic [2:0] c, input bit bt, input int wf,
                             input int wm, input int wmd);
    int n;
    logic [12:0] mwe;
    n = (wf > WL) ? WL + 1 : wf;
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, nz(), nz(), rnd_cls(), O_MREQ, FETCH);
    if (wf > WL) begin push_exc(rnd_cls()); return; end
    push(1'b1, 1'b1, nz(), nz(), rnd_cls(), O_MREQ | O_IR | O_PC, FETCH);
    push(nz(), nz(), nz(), nz(), c, O_A | O_B, DECODE);
    if (c >= 3'd6) begin push_exc(c); return; end
    case (c)
      CLS_ALU: begin
        push(nz(), nz(), nz(), nz(), c, O_ALU, EXEC);
        push(nz(), nz(), nz(), nz(), c, O_RF, WB);
      end
      CLS_LOAD, CLS_STORE: begin
        mwe = (c == CLS_STORE) ? O_MWE : 13'd0;
        push(nz(), nz(), nz(), nz(), c, O_ALU, EXEC);
        n = (wm > WL) ? WL + 1 : wm;
        for (int i = 0; i < n; i++) push(nz(), 1'b0, nz(), nz(), c, O_MREQ | mwe, MEM);
        if (wm > WL) begin push_exc(c); return; end
        push(nz(), 1'b1, nz(), nz(), c,
             O_MREQ | mwe | ((c == CLS_LOAD) ? O_MDR : 13'd0), MEM);
        if (c == CLS_LOAD) push(nz(), nz(), nz(), nz(), c, O_RF, WB);
      end
      CLS_BRANCH: push(nz(), nz(), nz(), bt, c, (bt ? O_PC : 13'd0) | 13'(PC_BRANCH), EXEC);
      CLS_JUMP:   push(nz(), nz(), nz(), nz(), c, O_PC | 13'(PC_JUMP), EXEC);
      default: begin
        push(nz(), nz(), nz(), nz(), c, O_MDS, EXEC);
        n = (wmd > WL) ? WL + 1 : wmd;
        for (int i = 0; i < n; i++) push(nz(), nz(), 1'b0, nz(), c, 13'd0, MDWAIT);
        if (wmd > WL) begin push_exc(c); return; end
        push(nz(), nz(), 1'b1, nz(), c, 13'd0, MDWAIT);
        push(nz(), nz(), nz(), nz(), c, O_RF, WB);
      end
    endcase
  endtask

  // Entered and left at 1 time unit after a rising edge; samples on the falling edge.
  task automatic play(input int upto);
    obs_o.delete();
    obs_s.delete();
    for (int i = 0; i < trace.size() && i < upto; i++) begin
      run = trace[i].run; mem_ready = trace[i].mr; md_done = trace[i].md;
      branch_taken = trace[i].bt; instr_class = trace[i].cls;
      @(negedge clk);
      obs_o.push_back(outs);
      obs_s.push_back(dut_state);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; md_done = 1'b1;
    branch_taken = 1'b1; instr_class = CLS_JUMP;
    #3;
    tests++;
    if (outs !== 13'd0 || dut_state !== 3'(FETCH)) begin
      failed++;
      $display("[TB] FAIL reset_initial: outputs=%h state=%0d, expected outputs=0 state=%0d", outs, dut_state, FETCH);
    end
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (outs !== 13'd0 || dut_state !== 3'(FETCH)) begin
      failed++;
      $display("[TB] FAIL reset_held: outputs=%h state=%0d, expected outputs=0 state=%0d", outs, dut_state, FETCH);
    end
    @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (outs !== 13'd0 || dut_state !== 3'(FETCH)) begin
      failed++;
      $display("[TB] FAIL reset_release_idle: outputs=%h state=%0d, expected outputs=0 state=%0d", outs, dut_state, FETCH);
    end
  endtask

  task automatic test_basic_classes();
    trace.delete();
    build_instr(CLS_ALU, 1'b0, 0, 0, 0);
    build_instr(CLS_STORE, 1'b0, 0, 0, 0);
    build_instr(CLS_BRANCH, 1'b1, 0, 0, 0);
    build_instr(CLS_BRANCH, 1'b0, 0, 0, 0);
    build_instr(CLS_JUMP, 1'b0, 2, 0, 0);
    build_instr(3'd6, 1'b0, 0, 0, 0);
    build_instr(3'd7, 1'b0, 1, 0, 0);
    play(trace.size());
    for (int i = 0; i < obs_o.size(); i++) begin
      tests++;
      if (obs_o[i] !== trace[i].eo || obs_s[i] !== trace[i].es) begin
        failed++;
        $display("[TB] FAIL basic cyc %0d: outputs=%h state=%0d, expected outputs=%h state=%0d", i, obs_o[i], obs_s[i], trace[i].eo, trace[i].es);
      end
    end
  endtask

  task automatic test_load_wait();
    int mdr_pulses = 0;
    trace.delete();
    build_instr(CLS_LOAD, 1'b0, 0, 3, 0);
    play(trace.size());
    for (int i = 0; i < obs_o.size(); i++) begin
      tests++;
      if (obs_o[i] !== trace[i].eo || obs_s[i] !== trace[i].es) begin
        failed++;
        $display("[TB] FAIL load_wait cyc %0d: outputs=%h state=%0d, expected outputs=%h state=%0d", i, obs_o[i], obs_s[i], trace[i].eo, trace[i].es);
      end
      if (obs_o[i][7]) mdr_pulses++;
    end
    tests++;
    if (mdr_pulses != 1) begin
      failed++;
      $display("[TB] FAIL load_mdr_pulses: got %0d, expected 1", mdr_pulses);
    end
  endtask

  task automatic test_muldiv();
    int starts = 0, waits = 0, writes = 0;
    trace.delete();
    build_instr(CLS_MULDIV, 1'b0, 0, 0, 9);
    play(trace.size());
    for (int i = 0; i < obs_o.size(); i++) begin
      tests++;
      if (obs_o[i] !== trace[i].eo || obs_s[i] !== trace[i].es) begin
        failed++;
        $display("[TB] FAIL muldiv cyc %0d: outputs=%h state=%0d, expected outputs=%h state=%0d", i, obs_o[i], obs_s[i], trace[i].eo, trace[i].es);
      end
      if (obs_o[i][3]) starts++;
      if (obs_o[i][6]) writes++;
      if (obs_s[i] == 3'(MDWAIT)) waits++;
    end
    tests++;
    if (starts != 1 || waits != 10 || writes != 1) begin
      failed++;
      $display("[TB] FAIL muldiv_shape: md_start=%0d mdwait=%0d rf_we=%0d, expected 1 10 1", starts, waits, writes);
    end
  endtask

  task automatic test_watchdog();
    int excs = 0;
    trace.delete();
    build_instr(CLS_MULDIV, 1'b0, 0, 0, 64);
    build_instr(CLS_MULDIV, 1'b0, 0, 0, 63);
    build_instr(CLS_LOAD, 1'b0, 0, 64, 0);
    build_instr(CLS_STORE, 1'b0, 0, 63, 0);
    build_instr(CLS_ALU, 1'b0, 64, 0, 0);
    build_instr(CLS_ALU, 1'b0, 63, 0, 0);
    play(trace.size());
    for (int i = 0; i < obs_o.size(); i++) begin
      tests++;
      if (obs_o[i] !== trace[i].eo || obs_s[i] !== trace[i].es) begin
        failed++;
        $display("[TB] FAIL watchdog cyc %0d: outputs=%h state=%0d, expected outputs=%h state=%0d", i, obs_o[i], obs_s[i], trace[i].eo, trace[i].es);
      end
      if (obs_o[i][2]) excs++;
    end
    tests++;
    if (excs != 3) begin
      failed++;
      $display("[TB] FAIL watchdog_exc_count: got %0d, expected 3", excs);
    end
  endtask

  task automatic test_run_pause();
    trace.delete();
    for (int i = 0; i < 40; i++) push(1'b1, 1'b0, nz(), nz(), rnd_cls(), O_MREQ, FETCH);
    for (int i = 0; i < 3; i++) push(1'b0, nz(), nz(), nz(), rnd_cls(), 13'd0, FETCH);
    build_instr(CLS_ALU, 1'b0, 63, 0, 0);
    play(trace.size());
    for (int i = 0; i < obs_o.size(); i++) begin
      tests++;
      if (obs_o[i] !== trace[i].eo || obs_s[i] !== trace[i].es) begin
        failed++;
        $display("[TB] FAIL run_pause cyc %0d: outputs=%h state=%0d, expected outputs=%h state=%0d", i, obs_o[i], obs_s[i], trace[i].eo, trace[i].es);
      end
    end
  endtask

  task automatic test_mid_reset();
    trace.delete();
    build_instr(CLS_LOAD, 1'b0, 0, 30, 0);
    play(8);
    for (int i = 0; i < obs_o.size(); i++) begin
      tests++;
      if (obs_o[i] !== trace[i].eo || obs_s[i] !== trace[i].es) begin
        failed++;
        $display("[TB] FAIL mid_reset_pre cyc %0d: outputs=%h state=%0d, expected outputs=%h state=%0d", i, obs_o[i], obs_s[i], trace[i].eo, trace[i].es);
      end
    end
    mem_ready = 1'b0;
    #1;
    tests++;
    if (dut_state !== 3'(MEM) || mem_req !== 1'b1) begin
      failed++;
      $display("[TB] FAIL mid_reset_in_mem: state=%0d mem_req=%b, expected state=%0d mem_req=1", dut_state, mem_req, MEM);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (dut_state !== 3'(FETCH) || outs !== 13'd0) begin
      failed++;
      $display("[TB] FAIL mid_reset_async: state=%0d outputs=%h, expected state=%0d outputs=0", dut_state, outs, FETCH);
    end
    @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      mem_ready = nz(); md_done = nz(); instr_class = rnd_cls();
      @(negedge clk);
      tests++;
      if (dut_state !== 3'(FETCH) || outs !== 13'd0) begin
        failed++;
        $display("[TB] FAIL post_reset_idle %0d: state=%0d outputs=%h, expected state=%0d outputs=0", i, dut_state, outs, FETCH);
      end
    end
    @(posedge clk);
    #1;
    trace.delete();
    build_instr(CLS_ALU, 1'b0, 0, 0, 0);
    play(trace.size());
    for (int i = 0; i < obs_o.size(); i++) begin
      tests++;
      if (obs_o[i] !== trace[i].eo || obs_s[i] !== trace[i].es) begin
        failed++;
        $display("[TB] FAIL mid_reset_post cyc %0d: outputs=%h state=%0d, expected outputs=%h state=%0d", i, obs_o[i], obs_s[i], trace[i].eo, trace[i].es);
      end
    end
  endtask

  task automatic test_random();
    int wf, wm, wmd;
    trace.delete();
    for (int k = 0; k < 150; k++) begin
      wf  = ($urandom_range(0, 24) == 0) ? int'($urandom_range(60, 68)) : int'($urandom_range(0, 3));
      wm  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(60, 68)) : int'($urandom_range(0, 4));
      wmd = ($urandom_range(0, 19) == 0) ? int'($urandom_range(60, 68)) : int'($urandom_range(0, 12));
      build_instr(rnd_cls(), nz(), wf, wm, wmd);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        push(1'b0, nz(), nz(), nz(), rnd_cls(), 13'd0, FETCH);
    end
    play(trace.size());
    for (int i = 0; i < obs_o.size(); i++) begin
      tests++;
      if (obs_o[i] !== trace[i].eo || obs_s[i] !== trace[i].es) begin
        failed++;
        $display("[TB] FAIL random cyc %0d: outputs=%h state=%0d, expected outputs=%h state=%0d", i, obs_o[i], obs_s[i], trace[i].eo, trace[i].es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_classes();
    test_load_wait();
    test_muldiv();
    test_watchdog();
    test_run_pause();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  in  1  controller clock; state advances on rising edge, so enables are stable before the datapath registers capture on the falling edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 run  in  1  execution enable, sampled only in FETCH.
REQ-004 instr_class  in  3  decoded class from IR: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 MULDIV, 6-7 illegal; valid from DECODE until the next FETCH.
REQ-005 branch_taken  in  1  branch condition, valid in EXEC.
REQ-006 mem_ready  in  1  memory acknowledge for the current mem_req.
REQ-007 md_done  in  1  single-cycle pulse from the mul/div unit.
REQ-008 pc_ena, ir_ena, a_ena, b_ena, alu_ena, mdr_ena  out  1 each  datapath register enables.
REQ-009 rf_we, mem_req, mem_we, md_start, exc  out  1 each  register-file write, memory request, memory write, mul/div start, exception flag.
REQ-010 pc_src  out  2  PC mux select: 0 PC+4, 1 branch target, 2 jump target, 3 exception vector.
REQ-011 state  out  3  current state encoding, for debug.
REQ-012 Parameter WDOG_LIMIT, default 63, is the maximum number of wait cycles before an exception.

Function
REQ-013 States SHALL be FETCH, DECODE, EXEC, MEM, WB, MDWAIT, EXC.
REQ-014 Outputs SHALL be combinational in state and inputs; every output not listed for a state SHALL be 0.
REQ-015 FETCH, run=0: hold FETCH with all outputs 0 and the wait counter cleared.
REQ-016 FETCH, run=1: mem_req=1; when mem_ready=1: ir_ena=1, pc_ena=1, pc_src=0, next state DECODE; otherwise stay.
REQ-017 DECODE: a_ena=b_ena=1; next state EXC if instr_class is 6 or 7, otherwise EXEC.
REQ-018 EXEC, ALU: alu_ena=1; next state WB.
REQ-019 EXEC, LOAD/STORE: alu_ena=1; next state MEM.
REQ-020 EXEC, BRANCH: pc_ena=branch_taken, pc_src=1; next state FETCH.
REQ-021 EXEC, JUMP: pc_ena=1, pc_src=2; next state FETCH.
REQ-022 EXEC, MULDIV: md_start=1 for exactly one cycle; next state MDWAIT.
REQ-023 MEM: mem_req=1, mem_we=(class==STORE); on mem_ready, LOAD asserts mdr_ena and goes to WB, STORE goes to FETCH.
REQ-024 MDWAIT: all outputs 0; on md_done go to WB.
REQ-025 WB: rf_we=1 for one cycle; next state FETCH.
REQ-026 EXC: exc=1, pc_ena=1, pc_src=3 for one cycle; next state FETCH.
REQ-027 Wait counter (6-bit) SHALL increment on each cycle spent in FETCH(run=1), MEM or MDWAIT without the awaited ready/done; it SHALL clear on any state change.
REQ-028 When the counter equals WDOG_LIMIT and ready/done is still absent, next state SHALL be EXC.
REQ-029 If ready/done and watchdog expiry coincide, ready/done SHALL win.
REQ-030 Latency with zero-wait memory, FETCH to FETCH: ALU 4, LOAD 5, STORE 4, BRANCH/JUMP 3, MULDIV 5+N cycles (N = md wait cycles).
REQ-031 md_done or mem_ready arriving outside its wait state SHALL be ignored.

Reset
REQ-032 rst=1 SHALL force state=FETCH and counter=0 immediately, regardless of clk, including mid-instruction.
REQ-033 During reset all outputs SHALL be 0, pc_src=0 and exc=0.
REQ-034 The first mem_req after reset release SHALL appear only when run=1.

Structure
REQ-035 Package mc_pkg SHALL hold the state encodings, instr_class codes, pc_src codes and the WDOG_LIMIT default.
REQ-036 The watchdog counter SHALL be the sub-module wait_timer (inputs clr, inc; output expired).

Verification
REQ-037 run=1, mem_ready=1, class=ALU -> ir_ena+pc_ena in cycle 1, a/b_ena in cycle 2, alu_ena in cycle 3, rf_we in cycle 4, back to FETCH.
REQ-038 LOAD with mem_ready held low 3 cycles in MEM -> mem_req stays high, mdr_ena pulses once on the 4th MEM cycle, then WB.
REQ-039 MULDIV, md_done after 10 cycles -> md_start is a single pulse, MDWAIT lasts 10 cycles, rf_we pulses once.
REQ-040 MDWAIT with md_done never asserted -> EXC after 64 wait cycles with exc=1, pc_src=3, pc_ena=1 for one cycle; md_done on the 64th cycle -> WB instead.
REQ-041 class=6 -> EXC directly after DECODE; BRANCH with branch_taken=0 -> pc_ena=0 in EXEC.
REQ-042 rst asserted mid-MEM, between clock edges -> state=FETCH and mem_req=0 immediately; no output pulses after release while run=0.
